wb_merge_queue: RTL



---
 rtl/wb_merge_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_merge_queue.sv
// wb_merge_queue
// Write-back merge stage in front of the register file write port.
// ALU results are always accepted and go straight to the output stage.
// Load results are buffered in an in-order FIFO. The FIFO drains only in
// cycles with no ALU write. A queued load is squashed (kill bit set) when a
// newer ALU write targets the same register.
//
// Configuration macro: WB_R0_DISCARD_EN
//   When defined, writes to register 0 are dropped. ALU r0 writes leave the
//   output stage free, and r0 loads are handshaken but not enqueued.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   alu_we/wrAdd/Data ALU result (always accepted)
//   ld_valid/ready    load handshake, ld_wrAdd/ld_wrData payload
//   wrEnable/wrAdd/wrData  registered register-file write port
//   busy_mask         per-register pending live write (combinational)
module wb_merge_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_wrAdd,
  input  logic [31:0] alu_wrData,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_wrAdd,
  input  logic [31:0] ld_wrData,
  output logic        wrEnable,
  output logic [4:0]  wrAdd,
  output logic [31:0] wrData,
  output logic [31:0] busy_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]       addrQ [DEPTH];
  logic [31:0]      dataQ [DEPTH];
  logic [DEPTH-1:0] killQ;
  logic [PW-1:0]    wrPtr, rdPtr;
  logic [CW-1:0]    count;

  logic [DEPTH-1:0] liveSlot;
  logic             aluTake, ldAccept, pushEn, popEn;

  assign ld_ready = (count < FULL);
  assign ldAccept = ld_valid && ld_ready;

`ifdef WB_R0_DISCARD_EN
  assign aluTake = alu_we && (alu_wrAdd != 5'd0);
  assign pushEn  = ldAccept && (ld_wrAdd != 5'd0);
`else
  assign aluTake = alu_we;
  assign pushEn  = ldAccept;
`endif

  assign popEn = !aluTake && (count != '0);

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] offset;
    liveSlot = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offset      = PW'(j) - rdPtr;
      liveSlot[j] = ({1'b0, offset} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      killQ    <= '0;
      wrEnable <= 1'b0;
      wrAdd    <= '0;
      wrData   <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (alu_we && liveSlot[j] && (addrQ[j] == alu_wrAdd)) killQ[j] <= 1'b1;
      end

      // The write slot is never live when pushing, so this cannot collide
      // with the squash loop above. A same-cycle ALU hit counts as newer.
      if (pushEn) begin
        addrQ[wrPtr] <= ld_wrAdd;
        dataQ[wrPtr] <= ld_wrData;
        killQ[wrPtr] <= alu_we && (alu_wrAdd == ld_wrAdd);
        wrPtr        <= wrPtr + 1'b1;
      end

      if (popEn) rdPtr <= rdPtr + 1'b1;

      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (aluTake) begin
        wrEnable <= 1'b1;
        wrAdd    <= alu_wrAdd;
        wrData   <= alu_wrData;
      end else if (popEn) begin
        wrEnable <= !killQ[rdPtr];
        wrAdd    <= addrQ[rdPtr];
        wrData   <= dataQ[rdPtr];
      end else begin
        wrEnable <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (liveSlot[j] && !killQ[j]) busy_mask[addrQ[j]] = 1'b1;
    end
    if (wrEnable) busy_mask[wrAdd] = 1'b1;
`ifdef WB_R0_DISCARD_EN
    busy_mask[0] = 1'b0;
`endif
  end

endmodule
